// File: rtl/wishbone_arbiter_2m_if.sv
// One Wishbone link between a bus master and a bus slave.
// The arbiter sees each requesting master through the slave modport and the interconnect through the master modport.
interface wishbone_arbiter_2m_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        intr;

  modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack, intr);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack, intr);
endinterface

// File: rtl/wishbone_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with per-cycle round-robin ownership
// and a watchdog that forces an ack on strobes the slave never answers.
module wishbone_arbiter_2m #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic                 clk,
  input  logic                 rst,
  wishbone_arbiter_2m_if.slave  m0,
  wishbone_arbiter_2m_if.slave  m1,
  wishbone_arbiter_2m_if.master s,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic [15:0] r_wd_cnt;
  logic        w_gnt0, w_gnt1, w_own_stb, w_fire;

  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_own_stb = (w_gnt0 & m0.stb) | (w_gnt1 & m1.stb);
  // A real ack in the expiry cycle wins over the watchdog.
  assign w_fire    = (TIMEOUT != 16'd0) && w_own_stb && !s.ack && (r_wd_cnt == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_wd_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (r_state == IDLE || s.ack || !w_own_stb || w_fire)
        r_wd_cnt <= 16'd0;
      else
        r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) w_state_nxt = r_last ? GNT0 : GNT1;
        else if (m0.cyc)      w_state_nxt = GNT0;
        else if (m1.cyc)      w_state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0.cyc) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = m1.cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = m0.cyc ? GNT0 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.cyc  = 1'b0;
    s.stb  = 1'b0;
    s.we   = 1'b0;
    s.sel  = 4'h0;
    s.adr  = 32'h0;
    s.wdat = 32'h0;
    if (w_gnt0) begin
      s.cyc  = m0.cyc;
      s.stb  = m0.stb & ~w_fire;
      s.we   = m0.we;
      s.sel  = m0.sel;
      s.adr  = m0.adr;
      s.wdat = m0.wdat;
    end else if (w_gnt1) begin
      s.cyc  = m1.cyc;
      s.stb  = m1.stb & ~w_fire;
      s.we   = m1.we;
      s.sel  = m1.sel;
      s.adr  = m1.adr;
      s.wdat = m1.wdat;
    end
  end

  assign m0.ack  = w_gnt0 & (s.ack | w_fire);
  assign m1.ack  = w_gnt1 & (s.ack | w_fire);
  assign m0.rdat = (w_gnt0 && !w_fire) ? s.rdat : 32'h0;
  assign m1.rdat = (w_gnt1 && !w_fire) ? s.rdat : 32'h0;
  assign m0.intr = s.intr;
  assign m1.intr = s.intr;

  assign grant_o   = r_state;
  assign timeout_o = w_fire;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Bench for wishbone_arbiter_2m: directed scenarios followed by random traffic,
// every cycle compared against an ownership/wait-count reference model.
module tb_wishbone_arbiter_2m;
  localparam int TO = 8;

  logic       clk, rst;
  logic [1:0] grant_o;
  logic       timeout_o;

  wishbone_arbiter_2m_if m0_bus ();
  wishbone_arbiter_2m_if m1_bus ();
  wishbone_arbiter_2m_if s_bus ();

  wishbone_arbiter_2m #(.TIMEOUT(16'(TO))) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (-1 none), who owned it last, and how
  // many consecutive cycles the owner's strobe has been waiting unanswered.
  int   mdl_owner = -1;
  int   mdl_last  = 1;
  int   mdl_wait  = 0;
  logic e_ostb, e_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle_check();
    logic        c, st, w, a0, a1;
    logic [3:0]  sl;
    logic [31:0] ad, wd, d0, d1;
    #2;
    c = 0; st = 0; w = 0; sl = 0; ad = 0; wd = 0;
    if (mdl_owner == 0) begin
      c = m0_bus.cyc; st = m0_bus.stb; w = m0_bus.we; sl = m0_bus.sel; ad = m0_bus.adr; wd = m0_bus.wdat;
    end else if (mdl_owner == 1) begin
      c = m1_bus.cyc; st = m1_bus.stb; w = m1_bus.we; sl = m1_bus.sel; ad = m1_bus.adr; wd = m1_bus.wdat;
    end
    e_ostb = st;
    e_fire = (TO != 0) && (mdl_owner >= 0) && st && !s_bus.ack && (mdl_wait == TO);
    a0 = (mdl_owner == 0) && (s_bus.ack || e_fire);
    a1 = (mdl_owner == 1) && (s_bus.ack || e_fire);
    d0 = (mdl_owner == 0 && !e_fire) ? s_bus.rdat : 32'h0;
    d1 = (mdl_owner == 1 && !e_fire) ? s_bus.rdat : 32'h0;
    chk("grant",   32'(grant_o),    (mdl_owner == 0) ? 32'd1 : (mdl_owner == 1) ? 32'd2 : 32'd0);
    chk("timeout", 32'(timeout_o),  32'(e_fire));
    chk("s_cyc",   32'(s_bus.cyc),  32'(c));
    chk("s_stb",   32'(s_bus.stb),  32'(st && !e_fire));
    chk("s_we",    32'(s_bus.we),   32'(w));
    chk("s_sel",   32'(s_bus.sel),  32'(sl));
    chk("s_adr",   s_bus.adr,       ad);
    chk("s_dat",   s_bus.wdat,      wd);
    chk("m0_ack",  32'(m0_bus.ack), 32'(a0));
    chk("m1_ack",  32'(m1_bus.ack), 32'(a1));
    chk("m0_dat",  m0_bus.rdat,     d0);
    chk("m1_dat",  m1_bus.rdat,     d1);
    chk("m0_int",  32'(m0_bus.intr), 32'(s_bus.intr));
    chk("m1_int",  32'(m1_bus.intr), 32'(s_bus.intr));
  endtask

  task automatic advance();
    if (rst) begin
      mdl_owner = -1; mdl_last = 1; mdl_wait = 0;
    end else begin
      if (mdl_owner < 0 || s_bus.ack || !e_ostb || e_fire) mdl_wait = 0;
      else mdl_wait++;
      if (mdl_owner < 0) begin
        if (m0_bus.cyc && m1_bus.cyc) mdl_owner = (mdl_last == 1) ? 0 : 1;
        else if (m0_bus.cyc)          mdl_owner = 0;
        else if (m1_bus.cyc)          mdl_owner = 1;
      end else if (mdl_owner == 0 && !m0_bus.cyc) begin
        mdl_last = 0; mdl_owner = m1_bus.cyc ? 1 : -1;
      end else if (mdl_owner == 1 && !m1_bus.cyc) begin
        mdl_last = 1; mdl_owner = m0_bus.cyc ? 0 : -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  task automatic idle_all();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.sel = 0; m0_bus.adr = 0; m0_bus.wdat = 0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.sel = 0; m1_bus.adr = 0; m1_bus.wdat = 0;
    s_bus.ack = 0; s_bus.rdat = 0; s_bus.intr = 0;
  endtask

  initial begin
    int          wd_seen;
    int          dead;
    logic [31:0] wdata [3];
    wdata[0] = 32'hA5A5A5A5; wdata[1] = 32'h5A5A5A5A; wdata[2] = 32'h0000FFFF;

    idle_all();
    rst = 1;
    @(posedge clk); #1;

    // reset values
    cycle();
    rst = 0;
    settle_check();
    chk("rst_grant", 32'(grant_o), 32'd0);
    advance();

    // single master read
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h0; m0_bus.sel = 4'hF;
    cycle();
    settle_check(); chk("rd_grant", 32'(grant_o), 32'd1); advance();
    cycle();
    s_bus.ack = 1; s_bus.rdat = 32'h00010001;
    settle_check();
    chk("rd_data", m0_bus.rdat, 32'h00010001);
    chk("rd_m1_ack", 32'(m1_bus.ack), 32'd0);
    advance();
    idle_all();
    cycle();

    // tie after reset: m0 first, handoff, then m0 wins again
    rst = 1; cycle(); rst = 0;
    m0_bus.cyc = 1; m1_bus.cyc = 1;
    cycle();
    settle_check(); chk("tie_first", 32'(grant_o), 32'd1); advance();
    m0_bus.cyc = 0;
    settle_check(); chk("tie_gap_cyc", 32'(s_bus.cyc), 32'd0); advance();
    settle_check(); chk("tie_handoff", 32'(grant_o), 32'd2); advance();
    m1_bus.cyc = 0;
    cycle();
    m0_bus.cyc = 1; m1_bus.cyc = 1;
    cycle();
    settle_check(); chk("tie_again", 32'(grant_o), 32'd1); advance();
    idle_all();
    cycle();
    cycle();

    // grant hold: m1 bursts three writes while m0 waits
    m1_bus.cyc = 1;
    cycle();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    for (int i = 0; i < 3; i++) begin
      m1_bus.stb = 1; m1_bus.we = 1; m1_bus.sel = 4'hF;
      m1_bus.adr = 32'h01000000 + 32'(4 * i); m1_bus.wdat = wdata[i];
      settle_check(); chk("hold_grant", 32'(grant_o), 32'd2); advance();
      s_bus.ack = 1;
      settle_check();
      chk("hold_adr", s_bus.adr, 32'h01000000 + 32'(4 * i));
      chk("hold_dat", s_bus.wdat, wdata[i]);
      advance();
      s_bus.ack = 0; m1_bus.stb = 0;
    end
    m1_bus.cyc = 0; m1_bus.we = 0;
    settle_check(); chk("hold_release", 32'(grant_o), 32'd2); advance();
    settle_check(); chk("hold_next", 32'(grant_o), 32'd1); advance();
    idle_all();
    cycle();

    // watchdog fires TO cycles after the strobe reached the slave
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h0F000000;
    cycle();
    wd_seen = -1;
    for (int k = 0; k < 20 && wd_seen < 0; k++) begin
      settle_check();
      if (timeout_o === 1'b1) begin
        wd_seen = k;
        chk("wd_ack", 32'(m0_bus.ack), 32'd1);
        chk("wd_dat", m0_bus.rdat, 32'd0);
        chk("wd_stb", 32'(s_bus.stb), 32'd0);
      end
      advance();
    end
    chk("wd_cycles", 32'(wd_seen), 32'(TO));
    idle_all();
    cycle();

    // real ack in the expiry cycle suppresses the watchdog
    m0_bus.cyc = 1; m0_bus.stb = 1;
    cycle();
    for (int k = 0; k < TO; k++) cycle();
    s_bus.ack = 1; s_bus.rdat = 32'h12345678;
    settle_check();
    chk("wd_race_to", 32'(timeout_o), 32'd0);
    chk("wd_race_dat", m0_bus.rdat, 32'h12345678);
    advance();
    idle_all();
    cycle();

    // interrupt while idle and while m1 owns
    s_bus.intr = 1;
    settle_check(); chk("int_idle", 32'(m0_bus.intr & m1_bus.intr), 32'd1); advance();
    m1_bus.cyc = 1; m1_bus.stb = 1;
    cycle();
    settle_check(); chk("int_m1", 32'(m0_bus.intr & m1_bus.intr), 32'd1); advance();

    // reset mid-GNT1 with strobe outstanding
    rst = 1;
    cycle();
    rst = 0; s_bus.ack = 1;
    settle_check();
    chk("rstmid_grant", 32'(grant_o), 32'd0);
    chk("rstmid_cyc", 32'(s_bus.cyc), 32'd0);
    chk("rstmid_ack", 32'(m1_bus.ack), 32'd0);
    advance();
    idle_all();
    cycle();

    // random traffic
    dead = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) dead = 1 - dead;
      m0_bus.cyc  = m0_bus.cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m1_bus.cyc  = m1_bus.cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m0_bus.stb  = m0_bus.cyc & ($urandom_range(0, 3) != 0);
      m1_bus.stb  = m1_bus.cyc & ($urandom_range(0, 3) != 0);
      m0_bus.we   = 1'($urandom); m1_bus.we = 1'($urandom);
      m0_bus.sel  = 4'($urandom); m1_bus.sel = 4'($urandom);
      m0_bus.adr  = $urandom;     m1_bus.adr = $urandom;
      m0_bus.wdat = $urandom;     m1_bus.wdat = $urandom;
      s_bus.ack   = (dead == 0) && ($urandom_range(0, 3) == 0);
      s_bus.rdat  = $urandom;
      s_bus.intr  = 1'($urandom);
      cycle();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
